// File: rtl/btn_defs_pkg.sv
// Shared button-conditioning definitions: FSM encoding and default timing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package btn_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_DN = 2'd1,
        DOWN   = 2'd2,
        ARM_UP = 2'd3
    } btn_state_t;

    // 1 ms sample tick at 100 MHz, 20 ms qualification, 1 s long press
    localparam int DEF_SAMPLE_DIV = 100000;
    localparam int DEF_STABLE_CNT = 20;
    localparam int DEF_HOLD_TICKS = 1000;

endpackage

// File: rtl/btn_debounce_sync.sv
// Two-flop synchroniser for one asynchronous bit, resets to 0.
// Latency: 2 clock cycles.
// Backpressure: none, sampled every cycle.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: level, press/release strobes and long-press flag.
// Latency: 2 sync cycles + STABLE_CNT sample ticks + 1 output register cycle.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
module btn_debounce
    import btn_defs::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic I_CLK,
    input  logic I_RESET_N,
    input  logic I_BTN,
    output logic O_LEVEL,
    output logic O_PRESS,
    output logic O_RELEASE,
    output logic O_HOLD
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PRESC_MAX   = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLD_TICKS);

    logic            s_btn;
    logic            s_tick;
    logic [PW-1:0]   presc;

    btn_state_t      state, state_nxt;
    logic [SW-1:0]   stable, stable_nxt;
    logic [HW-1:0]   hold, hold_nxt;
    logic            level_nxt, hold_flag_nxt, press_nxt, release_nxt;

    sync_2ff u_sync (
        .clk   (I_CLK),
        .rst_n (I_RESET_N),
        .d     (I_BTN),
        .q     (s_btn)
    );

    // Free-running: button activity never realigns the sample grid
    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            presc <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign s_tick = (presc == PRESC_MAX);

    always_comb begin
        state_nxt     = state;
        stable_nxt    = stable;
        hold_nxt      = hold;
        level_nxt     = O_LEVEL;
        hold_flag_nxt = O_HOLD;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        if (s_tick) begin
            case (state)
                IDLE: begin
                    if (s_btn) begin
                        state_nxt  = ARM_DN;
                        stable_nxt = SW'(1);
                    end
                end
                ARM_DN: begin
                    if (!s_btn) begin
                        state_nxt  = IDLE;
                        stable_nxt = '0;
                    // >= lets STABLE_CNT==1 commit on the second agreeing tick
                    end else if (stable >= STABLE_LAST) begin
                        state_nxt  = DOWN;
                        stable_nxt = '0;
                        hold_nxt   = '0;
                        level_nxt  = 1'b1;
                        press_nxt  = 1'b1;
                    end else begin
                        stable_nxt = stable + 1'b1;
                    end
                end
                DOWN: begin
                    if (!s_btn) begin
                        state_nxt  = ARM_UP;
                        stable_nxt = SW'(1);
                    end else begin
                        if (hold != HOLD_MAX) begin
                            hold_nxt = hold + 1'b1;
                        end
                        if (hold_nxt == HOLD_MAX) begin
                            hold_flag_nxt = 1'b1;
                        end
                    end
                end
                ARM_UP: begin
                    if (s_btn) begin
                        state_nxt  = DOWN;
                        stable_nxt = '0;
                    end else if (stable >= STABLE_LAST) begin
                        state_nxt     = IDLE;
                        stable_nxt    = '0;
                        level_nxt     = 1'b0;
                        hold_flag_nxt = 1'b0;
                        release_nxt   = 1'b1;
                    end else begin
                        stable_nxt = stable + 1'b1;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    stable_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state     <= IDLE;
            stable    <= '0;
            hold      <= '0;
            O_LEVEL   <= 1'b0;
            O_HOLD    <= 1'b0;
            O_PRESS   <= 1'b0;
            O_RELEASE <= 1'b0;
        end else begin
            state     <= state_nxt;
            stable    <= stable_nxt;
            hold      <= hold_nxt;
            O_LEVEL   <= level_nxt;
            O_HOLD    <= hold_flag_nxt;
            O_PRESS   <= press_nxt;
            O_RELEASE <= release_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised bench for btn_debounce with a run-length reference model and event scoreboard.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_btn_debounce;

    localparam int SAMPLE_DIV = 4;
    localparam int STABLE_CNT = 3;
    localparam int HOLD_TICKS = 8;
    localparam int NEED = (STABLE_CNT < 2) ? 2 : STABLE_CNT;

    logic I_CLK = 1'b0;
    logic I_RESET_N;
    logic I_BTN;
    logic O_LEVEL, O_PRESS, O_RELEASE, O_HOLD;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] kind;   // {press, release}
        int         edge_n;
        logic       level;
        logic       hold;
    } ev_t;

    ev_t  exp_q[$];

    // Reference state: edges since reset, raw-sample history, run of disagreeing ticks
    int   n_edge;
    logic hist[$];
    int   m_run;
    int   m_hold;
    logic m_level;
    logic m_hold_flag;

    btn_debounce #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .STABLE_CNT (STABLE_CNT),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .I_CLK     (I_CLK),
        .I_RESET_N (I_RESET_N),
        .I_BTN     (I_BTN),
        .O_LEVEL   (O_LEVEL),
        .O_PRESS   (O_PRESS),
        .O_RELEASE (O_RELEASE),
        .O_HOLD    (O_HOLD)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        n_edge      = 0;
        hist        = {1'b0, 1'b0};
        m_run       = 0;
        m_hold      = 0;
        m_level     = 1'b0;
        m_hold_flag = 1'b0;
        exp_q.delete();
    endtask

    // Reference model: the button value seen at a tick is the raw value two edges
    // back; an edge commits once NEED consecutive ticks disagree with the level.
    initial begin
        model_reset();
        forever begin
            @(posedge I_CLK);
            if (!I_RESET_N) begin
                model_reset();
            end else begin
                logic s;
                s = hist[0];
                if ((n_edge % SAMPLE_DIV) == SAMPLE_DIV - 1) begin
                    if (s != m_level) begin
                        m_run++;
                        if (m_run >= NEED) begin
                            ev_t e;
                            m_level = s;
                            m_run   = 0;
                            if (s) m_hold = 0;
                            else   m_hold_flag = 1'b0;
                            e.kind   = s ? 2'b10 : 2'b01;
                            e.edge_n = n_edge;
                            e.level  = m_level;
                            e.hold   = m_hold_flag;
                            exp_q.push_back(e);
                        end
                    end else begin
                        if (m_level && m_run == 0) begin
                            if (m_hold < HOLD_TICKS) m_hold++;
                            if (m_hold >= HOLD_TICKS) m_hold_flag = 1'b1;
                        end
                        m_run = 0;
                    end
                end
                void'(hist.pop_front());
                hist.push_back(I_BTN);
                n_edge++;
            end
        end
    end

    // Monitor: steady outputs every cycle, strobes against the scoreboard
    initial begin
        forever begin
            @(negedge I_CLK);
            if (!I_RESET_N) begin
                chk("rst_outputs", {O_LEVEL, O_PRESS, O_RELEASE, O_HOLD}, 0);
            end else begin
                chk("level", O_LEVEL, m_level);
                chk("hold", O_HOLD, m_hold_flag);
                if (O_PRESS || O_RELEASE) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_strobe", {O_PRESS, O_RELEASE}, 0);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("strobe_kind", {O_PRESS, O_RELEASE}, e.kind);
                        chk("strobe_edge", n_edge - 1, e.edge_n);
                        chk("strobe_level", O_LEVEL, e.level);
                        chk("strobe_hold", O_HOLD, e.hold);
                    end
                end else if (exp_q.size() != 0) begin
                    chk("missing_strobe", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Inputs change 1 time unit after a falling edge, well clear of the rising edge
    task automatic drive(input logic v, input int cyc);
        I_BTN = v;
        repeat (cyc) begin
            @(negedge I_CLK);
            #1;
        end
    endtask

    task automatic do_reset(input int cyc);
        I_RESET_N = 1'b0;
        #1;
        chk("rst_level", O_LEVEL, 0);
        chk("rst_press", O_PRESS, 0);
        chk("rst_release", O_RELEASE, 0);
        chk("rst_hold", O_HOLD, 0);
        repeat (cyc) begin
            @(negedge I_CLK);
            #1;
        end
        I_RESET_N = 1'b1;
    endtask

    int presses;
    always @(posedge I_CLK) if (O_PRESS) presses <= presses + 1;

    initial begin
        I_BTN     = 1'b0;
        I_RESET_N = 1'b0;
        presses   = 0;
        @(negedge I_CLK);
        #1;
        do_reset(3);

        // clean press and release
        drive(1'b1, 40);
        drive(1'b0, 40);

        // bounce: high phases too short to collect three agreeing ticks
        for (int i = 0; i < 12; i++) drive(i[0] ? 1'b0 : 1'b1, 5);
        drive(1'b0, 30);
        chk("level_after_bounce", O_LEVEL, 0);

        // release glitch of one tick while down
        drive(1'b1, 40);
        drive(1'b0, 4);
        drive(1'b1, 30);
        chk("level_after_glitch", O_LEVEL, 1);
        drive(1'b0, 30);

        // long press then release
        drive(1'b1, 70);
        chk("hold_after_long", O_HOLD, 1);
        drive(1'b0, 30);

        // reset mid-hold with the button still held, then requalify
        drive(1'b1, 70);
        do_reset(2);
        drive(1'b1, 40);
        chk("level_after_rst_press", O_LEVEL, 1);
        drive(1'b0, 30);

        // sub-tick pulse
        drive(1'b1, 2);
        drive(1'b0, 30);
        chk("level_after_pulse", O_LEVEL, 0);

        // randomised segments with occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset($urandom_range(1, 4));
            drive(1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end
        drive(1'b0, 40);

        chk("queue_drained", exp_q.size(), 0);
        chk("saw_presses", (presses > 5) ? 1 : 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
